// File: rtl/i2s_tdm_tx.sv
// Parametrised I2S / left-justified / TDM serialiser with its own bit clock.
// Whole frames arrive through a one-entry holding buffer; a missing frame produces silence.
module i2s_tdm_tx #(
    parameter int unsigned AUDIO_DW = 8,
    parameter int unsigned SLOT_DW  = 16,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CLK_DIV  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [1:0]                 mode_i,
    input  logic [NUM_CH*AUDIO_DW-1:0] frame_data_i,
    input  logic                       frame_valid_i,
    output logic                       frame_ready_o,
    input  logic                       underrun_clr_i,
    output logic                       sck_o,
    output logic                       ws_o,
    output logic                       sd_o,
    output logic                       frame_start_o,
    output logic                       underrun_o
);

    localparam int unsigned FW = NUM_CH * AUDIO_DW;
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned PW = (SLOT_DW > 1) ? $clog2(SLOT_DW) : 1;
    localparam int unsigned CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ModeI2s  = 2'b00,
        ModeLj   = 2'b01,
        ModeTdm  = 2'b10,
        ModeRsvd = 2'b11
    } mode_e;

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] slot_q, slot_d;
    logic [FW-1:0] hold_q, hold_d;
    logic [FW-1:0] active_q, active_d;
    mode_e         mode_q, mode_d;
    logic          ready_q, ready_d;
    logic          sck_q, sck_d;
    logic          ws_q, ws_d;
    logic          sd_q, sd_d;
    logic          fs_q, fs_d;
    logic          ur_q, ur_d;

    logic                tick, boundary, ur_set, pos_last, slot_last, sd_bit;
    logic [CW-1:0]       slot_nx;
    logic [AUDIO_DW-1:0] word;

    always_comb begin
        dcnt_d    = dcnt_q;
        pos_d     = pos_q;
        slot_d    = slot_q;
        hold_d    = hold_q;
        active_d  = active_q;
        mode_d    = mode_q;
        ready_d   = ready_q;
        ws_d      = ws_q;
        sd_d      = sd_q;
        fs_d      = 1'b0;
        ur_set    = 1'b0;
        word      = '0;
        sd_bit    = 1'b0;
        tick      = en_i && (dcnt_q == '0);
        boundary  = tick && (slot_q == '0) && (pos_q == '0);
        pos_last  = (pos_q == PW'(SLOT_DW - 1));
        slot_last = (slot_q == CW'(NUM_CH - 1));
        slot_nx   = pos_last ? (slot_last ? '0 : slot_q + 1'b1) : slot_q;

        sck_d = en_i && (dcnt_q >= DW'(CLK_DIV / 2));
        if (!en_i || dcnt_q == DW'(CLK_DIV - 1)) begin
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end

        // Frame boundary: refill the active frame from holding, bypass, or silence.
        if (boundary) begin
            mode_d = mode_e'(mode_i);
            fs_d   = 1'b1;
            if (!ready_q) begin
                active_d = hold_q;
                ready_d  = 1'b1;
            end else if (frame_valid_i) begin
                active_d = frame_data_i;
            end else begin
                active_d = '0;
                ur_set   = 1'b1;
            end
        end else if (frame_valid_i && ready_q) begin
            hold_d  = frame_data_i;
            ready_d = 1'b0;
        end

        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (slot_q == CW'(k)) word = active_d[k*AUDIO_DW +: AUDIO_DW];
        end
        // Positions at or beyond AUDIO_DW match no bit and yield padding zeros.
        for (int i = 0; i < int'(AUDIO_DW); i++) begin
            if (int'(pos_q) == int'(AUDIO_DW) - 1 - i) sd_bit = word[i];
        end

        if (!en_i) begin
            pos_d    = '0;
            slot_d   = '0;
            active_d = '0;
            ws_d     = 1'b0;
            sd_d     = 1'b0;
        end else if (tick) begin
            sd_d = sd_bit;
            unique case (mode_d)
                ModeLj:  ws_d = int'(slot_q) >= int'(NUM_CH / 2);
                ModeTdm: ws_d = pos_last && slot_last;
                default: ws_d = int'(slot_nx) >= int'(NUM_CH / 2);
            endcase
            pos_d  = pos_last ? '0 : pos_q + 1'b1;
            slot_d = slot_nx;
        end

        ur_d = ur_set | (ur_q & ~underrun_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dcnt_q   <= '0;
            pos_q    <= '0;
            slot_q   <= '0;
            hold_q   <= '0;
            active_q <= '0;
            mode_q   <= ModeI2s;
            ready_q  <= 1'b1;
            sck_q    <= 1'b0;
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            fs_q     <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            dcnt_q   <= dcnt_d;
            pos_q    <= pos_d;
            slot_q   <= slot_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            ready_q  <= ready_d;
            sck_q    <= sck_d;
            ws_q     <= ws_d;
            sd_q     <= sd_d;
            fs_q     <= fs_d;
            ur_q     <= ur_d;
        end
    end

    assign frame_ready_o = ready_q;
    assign sck_o         = sck_q;
    assign ws_o          = ws_q;
    assign sd_o          = sd_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: I2S, left-justified, TDM, underrun, bypass and disruptions.
module tb_i2s_tdm_tx;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic [15:0] frame_data_i = '0;
    logic        frame_valid_i = 1'b0;
    logic        underrun_clr_i = 1'b0;
    logic        frame_ready_o, sck_o, ws_o, sd_o, frame_start_o, underrun_o;

    logic        en_t = 1'b0;
    logic [1:0]  mode_t = 2'b10;
    logic [31:0] data_t = '0;
    logic        valid_t = 1'b0;
    logic        clr_t = 1'b0;
    logic        ready_t, sck_t, ws_t, sd_t, fs_t, ur_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_tdm_tx dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .mode_i         (mode_i),
        .frame_data_i   (frame_data_i),
        .frame_valid_i  (frame_valid_i),
        .frame_ready_o  (frame_ready_o),
        .underrun_clr_i (underrun_clr_i),
        .sck_o          (sck_o),
        .ws_o           (ws_o),
        .sd_o           (sd_o),
        .frame_start_o  (frame_start_o),
        .underrun_o     (underrun_o)
    );

    i2s_tdm_tx #(
        .AUDIO_DW (8),
        .SLOT_DW  (8),
        .NUM_CH   (4),
        .CLK_DIV  (8)
    ) dut_tdm (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_t),
        .mode_i         (mode_t),
        .frame_data_i   (data_t),
        .frame_valid_i  (valid_t),
        .frame_ready_o  (ready_t),
        .underrun_clr_i (clr_t),
        .sck_o          (sck_t),
        .ws_o           (ws_t),
        .sd_o           (sd_t),
        .frame_start_o  (fs_t),
        .underrun_o     (ur_t)
    );

    logic [31:0] sd_v, ws_v, ur_v, fs_v;
    logic        rdy0;
    int          sck_bad, fs_bad;

    // Called at the negedge just before a boundary tick; records one 32-bit frame (MSB = b0).
    task automatic capture(input int chg_k, input logic [1:0] nmode, input logic nvalid,
                           input logic [15:0] ndata, input int clr_k);
        sck_bad = 0;
        fs_bad  = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            sd_v[31-k] = sd_o;
            ws_v[31-k] = ws_o;
            ur_v[31-k] = underrun_o;
            fs_v[31-k] = frame_start_o;
            if (k == 0) rdy0 = frame_ready_o;
            if (sck_o !== 1'b0) sck_bad++;
            frame_valid_i  = 1'b0;
            underrun_clr_i = 1'b0;
            if (k == chg_k) begin
                mode_i        = nmode;
                frame_valid_i = nvalid;
                frame_data_i  = ndata;
            end
            if (k == clr_k) underrun_clr_i = 1'b1;
            for (int j = 1; j < 8; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    frame_valid_i  = 1'b0;
                    underrun_clr_i = 1'b0;
                end
                if (sck_o !== (j >= 4)) sck_bad++;
                if (frame_start_o !== 1'b0) fs_bad++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck_o); end
        checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL reset_ws got %b want 0", ws_o); end
        checks++; if (sd_o !== 1'b0) begin errors++; $display("FAIL reset_sd got %b want 0", sd_o); end
        checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start_o); end
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL reset_ur got %b want 0", underrun_o); end
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", frame_ready_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_i2s();
        frame_data_i  = {8'h3C, 8'hA5};
        frame_valid_i = 1'b1;
        @(negedge clk);
        frame_valid_i = 1'b0;
        checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL i2s_accept_ready got %b want 0", frame_ready_o); end
        mode_i = 2'b00;
        en_i   = 1'b1;
        // Next frame queued and mode switched to left-justified at b=10.
        capture(10, 2'b01, 1'b1, {8'h3C, 8'hA5}, -1);
        checks++; if (sd_v !== 32'hA5003C00) begin errors++; $display("FAIL i2s_sd got %h want %h", sd_v, 32'hA5003C00); end
        checks++; if (ws_v !== 32'h0001FFFE) begin errors++; $display("FAIL i2s_ws got %h want %h", ws_v, 32'h0001FFFE); end
        checks++; if (fs_v !== 32'h80000000 || fs_bad != 0) begin errors++; $display("FAIL i2s_fs got %h/%0d want 80000000/0", fs_v, fs_bad); end
        checks++; if (sck_bad != 0) begin errors++; $display("FAIL i2s_sck_period got %0d bad samples want 0", sck_bad); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL i2s_ready_after_load got %b want 1", rdy0); end
        checks++; if (ur_v !== 32'h0) begin errors++; $display("FAIL i2s_ur got %h want 0", ur_v); end
    endtask

    task automatic test_lj();
        capture(-1, 2'b01, 1'b0, 16'h0, -1);
        checks++; if (sd_v !== 32'hA5003C00) begin errors++; $display("FAIL lj_sd got %h want %h", sd_v, 32'hA5003C00); end
        checks++; if (ws_v !== 32'h0000FFFF) begin errors++; $display("FAIL lj_ws got %h want %h", ws_v, 32'h0000FFFF); end
        checks++; if (fs_v !== 32'h80000000) begin errors++; $display("FAIL lj_fs got %h want 80000000", fs_v); end
        checks++; if (ur_v !== 32'h0) begin errors++; $display("FAIL lj_ur got %h want 0", ur_v); end
    endtask

    task automatic test_underrun();
        capture(-1, 2'b01, 1'b0, 16'h0, 8);
        checks++; if (sd_v !== 32'h0) begin errors++; $display("FAIL ur_silence got %h want 0", sd_v); end
        checks++; if (ur_v !== 32'hFF800000) begin errors++; $display("FAIL ur_flag_clear got %h want ff800000", ur_v); end
        // Clear asserted on the very tick that sets the flag again.
        underrun_clr_i = 1'b1;
        capture(-1, 2'b01, 1'b0, 16'h0, -1);
        checks++; if (ur_v !== 32'hFFFFFFFF) begin errors++; $display("FAIL ur_set_wins got %h want ffffffff", ur_v); end
        checks++; if (sd_v !== 32'h0) begin errors++; $display("FAIL ur_silence2 got %h want 0", sd_v); end
    endtask

    task automatic test_bypass();
        frame_data_i  = {8'h5A, 8'hC3};
        frame_valid_i = 1'b1;
        capture(5, 2'b01, 1'b1, 16'hFFFF, 2);
        checks++; if (sd_v !== 32'hC3005A00) begin errors++; $display("FAIL byp_sd got %h want c3005a00", sd_v); end
        checks++; if (ur_v !== 32'hE0000000) begin errors++; $display("FAIL byp_ur got %h want e0000000", ur_v); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL byp_ready got %b want 1", rdy0); end
        checks++; if (ws_v !== 32'h0000FFFF) begin errors++; $display("FAIL byp_ws got %h want 0000ffff", ws_v); end
    endtask

    task automatic test_reset_mid();
        // Land on b=20, sixth cycle of the sck period (sck high).
        repeat (166) @(negedge clk);
        checks++; if (sck_o !== 1'b1) begin errors++; $display("FAIL mid_sck got %b want 1", sck_o); end
        checks++; if (sd_o !== 1'b1) begin errors++; $display("FAIL mid_sd got %b want 1", sd_o); end
        checks++; if (ws_o !== 1'b1) begin errors++; $display("FAIL mid_ws got %b want 1", ws_o); end
        frame_data_i  = 16'h1234;
        frame_valid_i = 1'b1;
        @(negedge clk);
        frame_valid_i = 1'b0;
        checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL mid_hold_ready got %b want 0", frame_ready_o); end
        rst_i = 1'b1;
        en_i  = 1'b0;
        @(negedge clk);
        checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", sck_o); end
        checks++; if (sd_o !== 1'b0) begin errors++; $display("FAIL rst_sd got %b want 0", sd_o); end
        checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL rst_ws got %b want 0", ws_o); end
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", frame_ready_o); end
        checks++; if (frame_start_o !== 1'b0 || underrun_o !== 1'b0) begin errors++; $display("FAIL rst_fs_ur got %b%b want 00", frame_start_o, underrun_o); end
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL rst_dropped_hold got %b want 1", frame_ready_o); end
    endtask

    task automatic test_tdm();
        logic [31:0] tsd, tws, tfs;
        data_t  = {8'h44, 8'h33, 8'h22, 8'h11};
        valid_t = 1'b1;
        @(negedge clk);
        valid_t = 1'b0;
        mode_t  = 2'b10;
        en_t    = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            tsd[31-k] = sd_t;
            tws[31-k] = ws_t;
            tfs[31-k] = fs_t;
            repeat (7) @(negedge clk);
        end
        en_t = 1'b0;
        checks++; if (tsd !== 32'h11223344) begin errors++; $display("FAIL tdm_sd got %h want 11223344", tsd); end
        checks++; if (tws !== 32'h00000001) begin errors++; $display("FAIL tdm_ws got %h want 00000001", tws); end
        checks++; if (tfs !== 32'h80000000) begin errors++; $display("FAIL tdm_fs got %h want 80000000", tfs); end
    endtask

    initial begin
        test_reset();
        test_i2s();
        test_lj();
        test_underrun();
        test_bypass();
        test_reset_mid();
        test_tdm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
